vga_life_render: RTL and testbench

Downstream display stage for the 16×16 Life board. Takes the live 256-bit cell map and the edit cursor coordinates and produces 640×480@60 Hz VGA timing with 8-bit RGB (3-3-2). The map is snapshotted once per frame during vertical blank, so generation updates never tear mid-frame. The cursor cell is outlined so the user can see which cell the toggle button will flip.

---
 rtl/vga_life_render.sv | 131 +++++++++++++
 tb/tb_vga_life_render.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_life_render.sv
// 640x480@60 Hz VGA renderer for the 16x16 Life board: the cell map is latched once
// per frame in vertical blank; grid lines, live cells and a cursor outline are drawn.
module vga_life_render #(
    parameter int CLK_DIV = 2,
    parameter int GRID_X0 = 128,
    parameter int GRID_Y0 = 48,
    parameter int CELL    = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] map_in,
    input  logic [3:0]   cursor_x,
    input  logic [3:0]   cursor_y,
    input  logic         cursor_en,
    output logic         hsync,
    output logic         vsync,
    output logic [7:0]   rgb,
    output logic         frame_start
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(CELL + 1);

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PX_MAX  = PW'(CELL - 1);
    localparam logic [9:0]    H_MAX   = 10'd799;
    localparam logic [9:0]    V_MAX   = 10'd524;
    // Cell counters are cleared on the pixel just before the grid starts.
    localparam logic [9:0]    X_RST   = 10'((GRID_X0 == 0) ? 799 : GRID_X0 - 1);
    localparam logic [9:0]    Y_RST   = 10'((GRID_Y0 == 0) ? 524 : GRID_Y0 - 1);
    localparam logic [9:0]    X_LO    = 10'(GRID_X0);
    localparam logic [9:0]    X_HI    = 10'(GRID_X0 + 16 * CELL - 1);
    localparam logic [9:0]    Y_LO    = 10'(GRID_Y0);
    localparam logic [9:0]    Y_HI    = 10'(GRID_Y0 + 16 * CELL - 1);

    localparam logic [7:0] C_BLANK  = 8'h00;
    localparam logic [7:0] C_BORDER = 8'b000_000_01;
    localparam logic [7:0] C_CURSOR = 8'b111_000_00;
    localparam logic [7:0] C_LINE   = 8'b010_010_01;
    localparam logic [7:0] C_LIVE   = 8'b000_111_00;

    typedef struct packed {
        logic [3:0]    row;
        logic [3:0]    col;
        logic [PW-1:0] py;
        logic [PW-1:0] px;
    } cell_pos_t;

    logic [DW-1:0] div;
    logic [9:0]    h, v;
    cell_pos_t     pos;
    logic [255:0]  snap;

    logic       pix_ce;
    logic       visible, in_grid, on_cursor;
    logic [7:0] pix_rgb;

    assign pix_ce = (div == '0);

    always_comb begin
        visible   = (h < 10'd640) && (v < 10'd480);
        in_grid   = (h >= X_LO) && (h <= X_HI) && (v >= Y_LO) && (v <= Y_HI);
        on_cursor = cursor_en && (pos.col == cursor_x) && (pos.row == cursor_y) &&
                    ((pos.px == '0) || (pos.px == PX_MAX) ||
                     (pos.py == '0) || (pos.py == PX_MAX));
        pix_rgb   = C_BLANK;
        if (!visible)                            pix_rgb = C_BLANK;
        else if (!in_grid)                       pix_rgb = C_BORDER;
        else if (on_cursor)                      pix_rgb = C_CURSOR;
        else if ((pos.px == '0) || (pos.py == '0)) pix_rgb = C_LINE;
        else if (snap[{pos.row, pos.col}])       pix_rgb = C_LIVE;
        else                                     pix_rgb = C_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            pos         <= '0;
            snap        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= C_BLANK;
            frame_start <= 1'b0;
        end else begin
            div         <= (div == DIV_MAX) ? '0 : div + 1'b1;
            frame_start <= 1'b0;
            if (pix_ce) begin
                // Outputs lag the counters by one pixel; sync and colour share this stage.
                hsync <= ~((h >= 10'd656) && (h <= 10'd751));
                vsync <= ~((v >= 10'd490) && (v <= 10'd491));
                rgb   <= pix_rgb;

                if (h == H_MAX) begin
                    h <= '0;
                    v <= (v == V_MAX) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end

                if (h == X_RST) begin
                    pos.px  <= '0;
                    pos.col <= '0;
                end else if (pos.px == PX_MAX) begin
                    pos.px  <= '0;
                    pos.col <= pos.col + 4'd1;
                end else begin
                    pos.px  <= pos.px + 1'b1;
                end

                if (h == H_MAX) begin
                    if (v == Y_RST) begin
                        pos.py  <= '0;
                        pos.row <= '0;
                    end else if (pos.py == PX_MAX) begin
                        pos.py  <= '0;
                        pos.row <= pos.row + 4'd1;
                    end else begin
                        pos.py  <= pos.py + 1'b1;
                    end
                end

                // Last pixel of the last visible line: latch the map for the next frame.
                if ((h == H_MAX) && (v == 10'd479)) begin
                    snap        <= map_in;
                    frame_start <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_life_render.sv
// Bench for vga_life_render: two instances (CLK_DIV 2 and 1) checked every clk against
// a pixel-index model, plus literal colour probes and sync/frame timing measurements.
module tb_vga_life_render;
    localparam int FRAME = 420000;
    localparam int NP    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, rst_b;
    logic [255:0] map_a, map_b;
    logic [3:0]   cx_a, cy_a, cx_b, cy_b;
    logic         ce_a, ce_b;
    logic         hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
    logic [7:0]   rgb_a, rgb_b;

    vga_life_render #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst_a), .map_in(map_a), .cursor_x(cx_a), .cursor_y(cy_a),
        .cursor_en(ce_a), .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a), .frame_start(fs_a));
    vga_life_render #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .map_in(map_b), .cursor_x(cx_b), .cursor_y(cy_b),
        .cursor_en(ce_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b), .frame_start(fs_b));

    typedef struct packed {
        bit           armed;
        bit           newpix;
        int           n;
        int           k;
        logic [255:0] snap;
        logic         hs, vs, fs;
        logic [7:0]   rgb;
    } model_t;

    typedef struct packed {
        int last_hf, hlow, vlow, last_fs, fs_cnt;
        bit vseen, hs_q, vs_q;
    } meas_t;

    typedef struct packed {
        int id, f, h, v;
        logic [7:0] want;
    } probe_t;

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    bit     fin_req = 0;
    bit     fin_done = 0;
    model_t ma, mb;
    meas_t  mea, meb, tmp;
    probe_t probes [NP];
    bit     hit [NP];

    function automatic logic [7:0] ref_rgb(int h, int v, logic [255:0] s,
                                           logic [3:0] cx, logic [3:0] cy, logic ce);
        int gx, gy, col, row, px, py;
        gx = h - 128;
        gy = v - 48;
        if (h >= 640 || v >= 480) return 8'h00;
        if (gx < 0 || gx >= 384 || gy < 0 || gy >= 384) return 8'h01;
        col = gx / 24; row = gy / 24; px = gx % 24; py = gy % 24;
        if (ce && col == int'(cx) && row == int'(cy) &&
            (px == 0 || px == 23 || py == 0 || py == 23)) return 8'hE0;
        if (px == 0 || py == 0) return 8'h49;
        if (s[row * 16 + col]) return 8'h1C;
        return 8'h00;
    endfunction

    function automatic model_t step(model_t m, int D, logic r, logic [255:0] mp,
                                    logic [3:0] cx, logic [3:0] cy, logic ce);
        model_t o;
        int p, h, v;
        o = m;
        o.newpix = 0;
        o.fs = 1'b0;
        if (r) begin
            o.armed = 1; o.n = 0; o.k = 0; o.snap = '0;
            o.hs = 1'b1; o.vs = 1'b1; o.rgb = 8'h00;
            return o;
        end
        if (!m.armed) return o;
        o.n = m.n + 1;
        if ((o.n - 1) % D == 0) begin
            o.k = (o.n - 1) / D;
            p = o.k % FRAME; h = p % 800; v = p / 800;
            o.newpix = 1;
            o.hs  = !(h >= 656 && h <= 751);
            o.vs  = !(v >= 490 && v <= 491);
            o.rgb = ref_rgb(h, v, m.snap, cx, cy, ce);
            if (h == 799 && v == 479) begin
                o.snap = mp;
                o.fs   = 1'b1;
            end
        end
        return o;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ma <= step(ma, 2, rst_a, map_a, cx_a, cy_a, ce_a);
    always @(posedge clk) mb <= step(mb, 1, rst_b, map_b, cx_b, cy_b, ce_b);

    task automatic expect_eq(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cyc %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic chk(input int id, input int D, input model_t m, input logic hs,
                       input logic vs, input logic fs, input logic [7:0] rgb,
                       input meas_t mi, output meas_t mo);
        int p;
        mo = mi;
        if (!m.armed) return;
        if (m.n == 0) begin
            mo.last_hf = -1; mo.hlow = -1; mo.vlow = -1; mo.last_fs = -1;
            mo.fs_cnt = 0; mo.vseen = 0;
        end
        checks++;
        if ({hs, vs, fs, rgb} !== {m.hs, m.vs, m.fs, m.rgb}) begin
            errors++;
            $display("FAIL out%0d n=%0d k=%0d got hs=%b vs=%b fs=%b rgb=%h want hs=%b vs=%b fs=%b rgb=%h",
                     id, m.n, m.k, hs, vs, fs, rgb, m.hs, m.vs, m.fs, m.rgb);
        end
        if (m.newpix) begin
            p = m.k % FRAME;
            for (int i = 0; i < NP; i++) begin
                if (probes[i].id == id && probes[i].f == m.k / FRAME &&
                    probes[i].h == p % 800 && probes[i].v == p / 800) begin
                    hit[i] = 1;
                    expect_eq($sformatf("probe%0d_d%0d_f%0d_(%0d,%0d)", i, D, probes[i].f,
                              probes[i].h, probes[i].v), int'(rgb), int'(probes[i].want));
                end
            end
        end
        if (mi.hs_q && !hs) begin
            if (mo.last_hf < 0) expect_eq($sformatf("hs_first_fall_d%0d", D), m.n - 1, 656 * D);
            else                expect_eq($sformatf("hs_period_d%0d", D), cyc - mo.last_hf, 800 * D);
            mo.last_hf = cyc;
            mo.hlow    = cyc;
        end
        if (!mi.hs_q && hs && mo.hlow >= 0)
            expect_eq($sformatf("hs_low_d%0d", D), cyc - mo.hlow, 96 * D);
        if (mi.vs_q && !vs) begin
            if (!mo.vseen) expect_eq($sformatf("vs_first_fall_d%0d", D), m.n - 1, 392000 * D);
            mo.vseen = 1;
            mo.vlow  = cyc;
        end
        if (!mi.vs_q && vs && mo.vlow >= 0)
            expect_eq($sformatf("vs_low_d%0d", D), cyc - mo.vlow, 1600 * D);
        if (fs) begin
            mo.fs_cnt++;
            if (mo.last_fs < 0) expect_eq($sformatf("fs_latency_d%0d", D), m.n - 1, 384000 * D - D);
            else                expect_eq($sformatf("fs_period_d%0d", D), cyc - mo.last_fs, FRAME * D);
            mo.last_fs = cyc;
        end
        mo.hs_q = hs;
        mo.vs_q = vs;
    endtask

    always @(negedge clk) begin
        int nhit;
        chk(0, 2, ma, hs_a, vs_a, fs_a, rgb_a, mea, tmp); mea = tmp;
        chk(1, 1, mb, hs_b, vs_b, fs_b, rgb_b, meb, tmp); meb = tmp;
        if (fin_req && !fin_done) begin
            nhit = 0;
            for (int i = 0; i < NP; i++) if (hit[i]) nhit++;
            expect_eq("probes_hit", nhit, NP);
            expect_eq("fs_count_d2", mea.fs_cnt, 1);
            expect_eq("fs_count_d1", meb.fs_cnt, 4);
            fin_done = 1;
        end
        if (errors >= 40 && !fin_done) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        // CLK_DIV=2 instance: all-ones map, cursor outline, mid-frame reset, cursor move.
        probes[0]  = '{0, 0, 511, 420, 8'hE0};
        probes[1]  = '{0, 0, 500, 431, 8'hE0};
        probes[2]  = '{0, 0, 500, 420, 8'h00};
        probes[3]  = '{0, 1, 128,  48, 8'hE0};
        probes[4]  = '{0, 1, 500, 420, 8'h1C};
        probes[5]  = '{0, 1, 511, 420, 8'h1C};
        // CLK_DIV=1 instance: single live cell, then all-ones written mid-frame.
        probes[6]  = '{1, 0, 130,  50, 8'h00};
        probes[7]  = '{1, 1, 130,  50, 8'h1C};
        probes[8]  = '{1, 1, 128,  50, 8'h49};
        probes[9]  = '{1, 1, 160,  50, 8'h00};
        probes[10] = '{1, 1, 100,  50, 8'h01};
        probes[11] = '{1, 1, 700,  50, 8'h00};
        probes[12] = '{1, 1, 160, 300, 8'h00};
        probes[13] = '{1, 2, 160,  50, 8'h1C};
        probes[14] = '{1, 2, 500, 420, 8'h1C};
        probes[15] = '{1, 2, 128,  50, 8'h49};

        rst_a = 1'b1; rst_b = 1'b1;
        map_a = '1;   map_b = 256'd1;
        cx_a = 4'd15; cy_a = 4'd15; ce_a = 1'b1;
        cx_b = 4'd0;  cy_b = 4'd0;  ce_b = 1'b0;

        wait_cyc(2);       rst_a = 1'b0; rst_b = 1'b0;
        wait_cyc(320601);  rst_a = 1'b1;          // lands on h=300, v=200 of the first frame
        wait_cyc(320602);  rst_a = 1'b0;
        wait_cyc(580100);  map_b = '1;            // v=200 of the second CLK_DIV=1 frame
        wait_cyc(1030000); cx_a = 4'd0; cy_a = 4'd0;
        wait_cyc(1840000); fin_req = 1;
        wait_cyc(1840003);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
